// File: rtl/cpu_fetch_decode_pkg.sv
// Shared picoMIPS configuration: field widths, instruction layout, opcode and ALU-function encodings.
package cpu_fetch_decode_pkg;

  localparam int N      = 8;
  localparam int O_SIZE = 4;
  localparam int R_SIZE = 4;
  localparam int P_SIZE = 5;
  localparam int A_SIZE = 2;
  localparam int I_SIZE = O_SIZE + 2 * R_SIZE + N;

  // Instruction layout, MSB first: opcode | rd | rs | imm
  localparam int OP_MSB  = I_SIZE - 1;
  localparam int RD_MSB  = OP_MSB - O_SIZE;
  localparam int RS_MSB  = RD_MSB - R_SIZE;
  localparam int IMM_MSB = RS_MSB - R_SIZE;

  typedef enum logic [O_SIZE-1:0] {
    NOP  = 4'd0,
    LDI  = 4'd1,
    ADD  = 4'd2,
    ADDI = 4'd3,
    MUL  = 4'd4
  } opCode_t;

  typedef enum logic [A_SIZE-1:0] {
    ALU_A   = 2'd0,
    ALU_B   = 2'd1,
    ALU_ADD = 2'd2,
    ALU_MUL = 2'd3
  } aluFunc_t;

  function automatic logic op_legal(input logic [O_SIZE-1:0] op);
    return (op <= O_SIZE'(MUL));
  endfunction

endpackage

// File: rtl/cpu_fetch_decode_instr_decoder.sv
// Combinational decode of the instruction register into the ALU / register-file control set.
module cpu_fetch_decode_instr_decoder
  import cpu_fetch_decode_pkg::*;
(
  input  logic [I_SIZE-1:0] ir,
  input  logic              issue,
  input  logic              mul2,
  output logic [A_SIZE-1:0] alu_func,
  output logic [R_SIZE-1:0] rd_addr,
  output logic [R_SIZE-1:0] rs_addr,
  output logic [N-1:0]      imm,
  output logic              imm_sel,
  output logic              reg_we
);

  logic [O_SIZE-1:0] op;

  assign op      = ir[OP_MSB -: O_SIZE];
  assign rd_addr = ir[RD_MSB -: R_SIZE];
  assign rs_addr = ir[RS_MSB -: R_SIZE];
  assign imm     = ir[IMM_MSB -: N];

  // Undefined opcodes fall through to the NOP defaults.
  always_comb begin
    alu_func = ALU_A;
    imm_sel  = 1'b0;
    reg_we   = 1'b0;
    case (op)
      LDI: begin
        alu_func = ALU_B;
        imm_sel  = 1'b1;
        reg_we   = issue;
      end
      ADD: begin
        alu_func = ALU_ADD;
        reg_we   = issue;
      end
      ADDI: begin
        alu_func = ALU_ADD;
        imm_sel  = 1'b1;
        reg_we   = issue;
      end
      MUL: begin
        alu_func = ALU_MUL;
        reg_we   = issue & mul2;
      end
      default: begin
        alu_func = ALU_A;
      end
    endcase
  end

endmodule

// File: rtl/cpu_fetch_decode.sv
// picoMIPS front end: PC, synchronous-ROM fetch, instruction register and FETCH/EXEC/MUL2 sequencing.
module cpu_fetch_decode
  import cpu_fetch_decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [P_SIZE-1:0] pmem_addr,
  input  logic [I_SIZE-1:0] pmem_data,
  output logic [A_SIZE-1:0] alu_func,
  output logic [R_SIZE-1:0] rd_addr,
  output logic [R_SIZE-1:0] rs_addr,
  output logic [N-1:0]      imm,
  output logic              imm_sel,
  output logic              reg_we,
  output logic              illegal
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MUL2  = 2'd2
  } state_t;

  state_t            state;
  logic [P_SIZE-1:0] pc;
  logic [I_SIZE-1:0] ir;
  logic [O_SIZE-1:0] op;
  logic              issue;
  logic              in_mul2;

  assign pmem_addr = pc;
  assign op        = ir[OP_MSB -: O_SIZE];
  assign issue     = (state == EXEC) || (state == MUL2);
  assign in_mul2   = (state == MUL2);

  // PC only moves on the way out of EXEC/MUL2, so the ROM address is stable through FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (run) begin
            ir    <= pmem_data;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (op == O_SIZE'(MUL)) begin
            state <= MUL2;
          end else begin
            state <= FETCH;
            pc    <= pc + P_SIZE'(1);
            if (!op_legal(op)) begin
              illegal <= 1'b1;
            end
          end
        end
        MUL2: begin
          state <= FETCH;
          pc    <= pc + P_SIZE'(1);
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  cpu_fetch_decode_instr_decoder u_dec (
    .ir       (ir),
    .issue    (issue),
    .mul2     (in_mul2),
    .alu_func (alu_func),
    .rd_addr  (rd_addr),
    .rs_addr  (rs_addr),
    .imm      (imm),
    .imm_sel  (imm_sel),
    .reg_we   (reg_we)
  );

endmodule
